// File: rtl/addr_sequencer.sv
// Address-register sequencer: arbitrates PC-bus fetches against ALU-bus load/stores and steps
// multi-word transfers via the incrementer. Define ADDR_SEQ_FAIR_ARB_EN for round-robin arbitration.
module addr_sequencer #(
  parameter int unsigned COUNT_W      = 4,
  parameter logic [1:0]  RESET_SELECT = 2'b01
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic               data_req,
  input  logic [COUNT_W-1:0] data_count,
  input  logic               mem_ready,
  output logic [1:0]         addr_select,
  output logic               addr_update,
  output logic               mem_req,
  output logic               fetch_grant,
  output logic               data_grant,
  output logic               fetch_done,
  output logic               data_done,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StAccess, StDone} state_e;
  typedef enum logic [1:0] {OwnNone, OwnFetch, OwnData} owner_e;

  localparam logic [1:0] SelAlu = 2'b00;
  localparam logic [1:0] SelPc  = 2'b01;
  localparam logic [1:0] SelInc = 2'b10;

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [1:0]         sel_q, sel_d;

  logic upd_q, upd_d;
  logic mreq_q, mreq_d;
  logic fgrant_q, fgrant_d;
  logic dgrant_q, dgrant_d;
  logic fdone_q, fdone_d;
  logic ddone_q, ddone_d;
  logic busy_q, busy_d;

  logic pick_data;

`ifdef ADDR_SEQ_FAIR_ARB_EN
  logic last_data_q, last_data_d;

  // On contention the requester not served last wins; a lone requester always wins.
  assign pick_data = data_req && (!fetch_req || !last_data_q);

  always_comb begin
    last_data_d = last_data_q;
    if (state_q == StIdle && (data_req || fetch_req)) begin
      last_data_d = pick_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_data_q <= 1'b0;
    end else begin
      last_data_q <= last_data_d;
    end
  end
`else
  assign pick_data = data_req;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= OwnNone;
      count_q <= '0;
      sel_q   <= RESET_SELECT;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      count_q <= count_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    count_d = count_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (data_req || fetch_req) begin
          state_d = StLoad;
          if (pick_data) begin
            owner_d = OwnData;
            count_d = data_count;
            sel_d   = SelAlu;
          end else begin
            owner_d = OwnFetch;
            count_d = '0;
            sel_d   = SelPc;
          end
        end
      end
      StLoad: state_d = StAccess;
      StAccess: begin
        if (mem_ready) begin
          // Decrementing only on a nonzero count keeps the last beat from wrapping.
          if (count_q != '0) begin
            count_d = count_q - COUNT_W'(1);
            sel_d   = SelInc;
            state_d = StLoad;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        owner_d = OwnNone;
      end
      default: begin
        state_d = StIdle;
        owner_d = OwnNone;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered copies line up with it.
  always_comb begin
    upd_d    = (state_d == StLoad);
    mreq_d   = (state_d == StAccess);
    busy_d   = (state_d != StIdle);
    fgrant_d = busy_d && (owner_d == OwnFetch);
    dgrant_d = busy_d && (owner_d == OwnData);
    fdone_d  = (state_d == StDone) && (owner_d == OwnFetch);
    ddone_d  = (state_d == StDone) && (owner_d == OwnData);
  end

  // Output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_q    <= 1'b0;
      mreq_q   <= 1'b0;
      fgrant_q <= 1'b0;
      dgrant_q <= 1'b0;
      fdone_q  <= 1'b0;
      ddone_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      upd_q    <= upd_d;
      mreq_q   <= mreq_d;
      fgrant_q <= fgrant_d;
      dgrant_q <= dgrant_d;
      fdone_q  <= fdone_d;
      ddone_q  <= ddone_d;
      busy_q   <= busy_d;
    end
  end

  assign addr_select = sel_q;
  assign addr_update = upd_q;
  assign mem_req     = mreq_q;
  assign fetch_grant = fgrant_q;
  assign data_grant  = dgrant_q;
  assign fetch_done  = fdone_q;
  assign data_done   = ddone_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_addr_sequencer.sv
// Bench for addr_sequencer: transaction-level model expands each grant into its expected
// per-cycle output timeline; one compare process checks every cycle.
module tb_addr_sequencer;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          fetch_req;
  logic          data_req;
  logic [CW-1:0] data_count;
  logic          mem_ready;
  logic [1:0]    addr_select;
  logic          addr_update;
  logic          mem_req;
  logic          fetch_grant;
  logic          data_grant;
  logic          fetch_done;
  logic          data_done;
  logic          busy;

  addr_sequencer #(
    .COUNT_W     (CW),
    .RESET_SELECT(2'b01)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .data_req   (data_req),
    .data_count (data_count),
    .mem_ready  (mem_ready),
    .addr_select(addr_select),
    .addr_update(addr_update),
    .mem_req    (mem_req),
    .fetch_grant(fetch_grant),
    .data_grant (data_grant),
    .fetch_done (fetch_done),
    .data_done  (data_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic       upd;
    logic       mreq;
    logic       fg;
    logic       dg;
    logic       fd;
    logic       dd;
    logic       busy;
    logic       acc;  // expected ACCESS cycle: bench drives the planned mem_ready
    logic       rdy;
  } vec_t;

  vec_t       exp_q[$];
  vec_t       exp_now;
  logic [1:0] model_sel;
  bit         last_data;
  bit         chk_en;
  int         total;
  int         bad;
  int         cyc;

  int         req_mode;    // 0 random, 1 fetch, 2 data, 3 both, 4 none
  bit         cnt_rand;
  logic [CW-1:0] cnt_fix;
  int         stall_mode;  // 0 random, 1 two-cycle stall on beat 1, 2 none

  logic [10:0] obs;
  assign obs = {addr_select, addr_update, mem_req, fetch_grant, data_grant,
                fetch_done, data_done, busy, 2'b00};

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (obs[10:2] !== exp_now[10:2]) begin
        bad++;
        $display("FAIL cycle_outputs cyc=%0d got sel/upd/mreq/fg/dg/fd/dd/busy=%b required=%b",
                 cyc, obs[10:2], exp_now[10:2]);
      end
    end
  end

  task automatic chk(input string name, input int got, input int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  function automatic vec_t idle_vec();
    vec_t v;
    v = '0;
    v.sel = model_sel;
    return v;
  endfunction

  function automatic int stall_of(input int b);
    if (stall_mode == 0) return $urandom_range(0, 3);
    if (stall_mode == 1) return (b == 1) ? 2 : 0;
    return 0;
  endfunction

  // Expand one granted transfer into its per-cycle output timeline.
  task automatic plan(input bit is_data, input int beats);
    vec_t       v;
    logic [1:0] s;
    int         st;
    s = 2'b00;
    for (int b = 0; b < beats; b++) begin
      s = (b == 0) ? (is_data ? 2'b00 : 2'b01) : 2'b10;
      v = '0; v.sel = s; v.upd = 1'b1; v.fg = !is_data; v.dg = is_data; v.busy = 1'b1;
      exp_q.push_back(v);
      st = stall_of(b);
      for (int k = 0; k <= st; k++) begin
        v = '0; v.sel = s; v.mreq = 1'b1; v.fg = !is_data; v.dg = is_data; v.busy = 1'b1;
        v.acc = 1'b1; v.rdy = (k == st);
        exp_q.push_back(v);
      end
    end
    v = '0; v.sel = s; v.fg = !is_data; v.dg = is_data; v.fd = !is_data; v.dd = is_data;
    v.busy = 1'b1;
    exp_q.push_back(v);
  endtask

  // Advance one cycle: take the expected outputs for it, then drive this cycle's inputs.
  task automatic step();
    bit is_data;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0) exp_now = exp_q.pop_front();
    else exp_now = idle_vec();
    model_sel = exp_now.sel;
    case (req_mode)
      0: begin fetch_req = 1'($urandom_range(0, 1)); data_req = 1'($urandom_range(0, 1)); end
      1: begin fetch_req = 1'b1; data_req = 1'b0; end
      2: begin fetch_req = 1'b0; data_req = 1'b1; end
      3: begin fetch_req = 1'b1; data_req = 1'b1; end
      default: begin fetch_req = 1'b0; data_req = 1'b0; end
    endcase
    data_count = cnt_rand ? CW'($urandom_range(0, 15)) : cnt_fix;
    mem_ready  = exp_now.acc ? exp_now.rdy : 1'($urandom_range(0, 1));
    if (!rst && !exp_now.busy && exp_q.size() == 0 && (fetch_req || data_req)) begin
`ifdef ADDR_SEQ_FAIR_ARB_EN
      is_data = data_req && (!fetch_req || !last_data);
`else
      is_data = data_req;
`endif
      last_data = is_data;
      plan(is_data, is_data ? int'(data_count) + 1 : 1);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    exp_q.delete();
    model_sel = 2'b01;
    last_data = 1'b0;
    exp_now   = idle_vec();
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_mem_req", mem_req, 0);
    chk("rst_async_grants", {fetch_grant, data_grant}, 0);
    chk("rst_async_sel", addr_select, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int upd_n, dd_n, busy_n, gn;
    bit seen;
    logic [7:0] sel_seq;
    logic [3:0] order;

    rst = 1'b1; fetch_req = 1'b0; data_req = 1'b0; data_count = '0; mem_ready = 1'b0;
    total = 0; bad = 0; cyc = 0; model_sel = 2'b01; last_data = 1'b0;
    req_mode = 4; cnt_rand = 1'b0; cnt_fix = '0; stall_mode = 2;
    exp_now = idle_vec();
    chk_en = 1'b1;
    step();
    step();
    chk("reset_sel", addr_select, 1);
    chk("reset_others", {addr_update, mem_req, fetch_grant, data_grant, fetch_done,
                         data_done, busy}, 0);
    rst = 1'b0;

    // Single fetch with an immediately ready memory.
    req_mode = 1;
    step();
    req_mode = 4;
    step();
    chk("fetch_c2_update", addr_update, 1);
    chk("fetch_c2_sel", addr_select, 1);
    chk("fetch_c2_grant", fetch_grant, 1);
    step();
    chk("fetch_c3_mem_req", mem_req, 1);
    step();
    chk("fetch_c4_done", fetch_done, 1);
    chk("fetch_c4_grant", fetch_grant, 1);
    step();
    chk("fetch_c5_grant_drop", {fetch_grant, busy}, 0);

    // Four-beat burst, two stall cycles on the second beat.
    req_mode = 2; cnt_fix = 4'd3; stall_mode = 1;
    step();
    req_mode = 4;
    upd_n = 0; busy_n = 0; sel_seq = '0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (busy) busy_n++;
      if (addr_update) begin upd_n++; sel_seq = {sel_seq[5:0], addr_select}; end
      if (data_done) seen = 1'b1;
    end
    chk("burst_done_seen", seen, 1);
    chk("burst_updates", upd_n, 4);
    chk("burst_sel_seq", sel_seq, 8'b00_10_10_10);
    chk("burst_busy_cycles", busy_n, 11);

    // Maximum burst: all-ones count gives 16 beats and no wrap.
    req_mode = 2; cnt_fix = 4'hF; stall_mode = 0;
    step();
    req_mode = 4;
    upd_n = 0; dd_n = 0;
    for (int i = 0; i < 200 && dd_n == 0; i++) begin
      step();
      if (addr_update) upd_n++;
      if (data_done) dd_n++;
    end
    repeat (3) begin
      step();
      if (addr_update) upd_n++;
      if (data_done) dd_n++;
    end
    chk("maxburst_updates", upd_n, 16);
    chk("maxburst_done_count", dd_n, 1);
    chk("maxburst_idle_after", busy, 0);

    // Reset in the middle of the second beat's ACCESS of a four-beat transfer.
    req_mode = 2; cnt_fix = 4'd3; stall_mode = 2;
    step();
    req_mode = 4;
    repeat (4) step();
    chk("midrst_in_access", mem_req, 1);
    apply_reset();
    dd_n = 0;
    repeat (2) begin
      step();
      if (data_done) dd_n++;
    end
    rst = 1'b0;
    req_mode = 1;
    step();
    req_mode = 4;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (data_done) dd_n++;
      if (fetch_done) seen = 1'b1;
    end
    chk("midrst_no_data_done", dd_n, 0);
    chk("midrst_fetch_after", seen, 1);

    // Contention from reset: both requests held across four transfers.
    step();
    apply_reset();
    step();
    rst = 1'b0;
    req_mode = 3; cnt_rand = 1'b1; stall_mode = 0;
    gn = 0; order = '0;
    for (int i = 0; i < 600 && gn < 4; i++) begin
      step();
      if (addr_update && addr_select != 2'b10) begin
        order = {order[2:0], data_grant};
        gn++;
      end
    end
    chk("contention_grants", gn, 4);
`ifdef ADDR_SEQ_FAIR_ARB_EN
    chk("contention_order", order, 4'b1010);
`else
    chk("contention_order", order, 4'b1111);
`endif

    // Randomized traffic, checked every cycle against the model.
    req_mode = 0; cnt_rand = 1'b1; stall_mode = 0;
    repeat (1500) step();
    req_mode = 4;
    for (int i = 0; i < 200 && (exp_q.size() > 0 || exp_now.busy); i++) step();
    chk("drain_idle", busy, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addr_sequencer.md
Name: addr_sequencer

Overview:
- Controller for the CPU address register.
- Arbitrates between the instruction-fetch requester (PC bus) and the load/store requester (ALU bus).
- Drives the address register's source select and update strobe, and handshakes each memory beat.
- Sequences multi-word data transfers by re-loading the address from the incrementer bus between beats.

Parameters:
COUNT_W, 4, width of the beat counter; max transfer = 2^COUNT_W words
RESET_SELECT, 2'b01, value of addr_select out of reset (PC bus)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
fetch_req  input  1  instruction fetch request; level, held until fetch_done
data_req  input  1  load/store request; level, held until data_done
data_count  input  COUNT_W  data beats minus 1 (0 = single word); sampled at data grant only
mem_ready  input  1  memory completed current beat; sampled only in ACCESS
addr_select  output  2  address register source: 00 ALU, 01 PC, 10 incrementer
addr_update  output  1  one-cycle strobe; address register loads on it
mem_req  output  1  memory beat request, high throughout ACCESS
fetch_grant  output  1  high from grant until fetch_done inclusive
data_grant  output  1  high from grant until data_done inclusive
fetch_done  output  1  one-cycle pulse, fetch transfer complete
data_done  output  1  one-cycle pulse, all data beats complete
busy  output  1  state != IDLE

Behaviour:
- All outputs are registered.
- Reset: state IDLE, beat counter 0, owner none. addr_select=RESET_SELECT; every other output 0.
- Reset asserted mid-transfer aborts immediately; no done pulse is issued.
- States: IDLE, LOAD, ACCESS, DONE.
- IDLE:
  - If data_req=1, grant data: owner=DATA, beat counter <= data_count, next LOAD with addr_select=00.
  - Else if fetch_req=1, grant fetch: owner=FETCH, counter <= 0, next LOAD with addr_select=01.
  - Default priority is data over fetch.
  - Grant output rises on entry to LOAD.
- LOAD (1 cycle): addr_update=1, mem_req=0. Next ACCESS.
- ACCESS: mem_req=1, addr_update=0. Stay while mem_ready=0; no timeout.
- ACCESS with mem_ready=1:
  - If counter != 0: decrement, next LOAD with addr_select=10 (incrementer).
  - If counter = 0: next DONE.
- DONE (1 cycle): owner's done pulse=1, mem_req=0. Grant is still high this cycle and drops on the next.
- Next state after DONE is IDLE; there is no same-cycle re-grant.
- Latency:
  - Request to first addr_update: 2 cycles (IDLE sample, LOAD).
  - Minimum single-beat transfer: IDLE->LOAD->ACCESS->DONE, so done appears 3 cycles after the request is sampled, with mem_ready=1 immediately.
- Each additional beat costs LOAD + ACCESS (≥2 cycles).
- addr_select holds its last value outside LOAD.
- Request deassertion during a transfer is ignored; the transfer completes.
- data_count changes after grant are ignored.
- Counter boundary: data_count = all-ones gives 2^COUNT_W beats. The counter never wraps, because decrement happens only when counter != 0.
- mem_ready outside ACCESS is ignored.

Optional Feature:
- Macro: ADDR_SEQ_FAIR_ARB_EN.
- Defined: round-robin arbitration. A one-bit last_owner register (reset = FETCH) tracks the previous owner. When both requests are high in IDLE, the requester not served last wins. A single requester always wins.
- Undefined: fixed data-over-fetch priority. No last_owner register.

Test Plan:
- Reset: assert rst mid-ACCESS of a 4-beat data transfer -> outputs immediately 0, addr_select=01, busy=0. No data_done. After release, fetch_req=1 proceeds normally.
- Single fetch: fetch_req=1, mem_ready tied 1 -> addr_update pulse with addr_select=01 at cycle 2, mem_req at cycle 3, fetch_done pulse at cycle 4, fetch_grant cycles 2-4.
- Burst: data_req=1, data_count=3, mem_ready stalls 2 cycles on beat 2:
  - 4 addr_update pulses with addr_select sequence 00,10,10,10.
  - data_done once after the 4th mem_ready.
  - Total 4+2 extra wait cycles.
- Max burst: data_count=4'hF -> exactly 16 addr_update pulses, counter does not wrap, single data_done.
- Contention, macro undefined: fetch_req and data_req both held high across 3 transfers -> grants data, data, data (fetch starved while data_req high).
- Contention, macro defined: fetch_req and data_req both held high, starting from reset -> grants data, fetch, data, fetch. Never two grants overlapping; ≥1 IDLE cycle between DONE and next LOAD.
